// File: rtl/hazard_glitch_filter_if.sv
// Signal bundle between a hazard-prone net source and the glitch filter.
// The master side drives the raw net and the counter clear; the slave side is the filter.
interface hazard_glitch_filter_if #(
    parameter int unsigned CNT_W = 8
);
    logic             z_in;
    logic             cnt_clr;
    logic             z_clean;
    logic             edge_pulse;
    logic             glitch_pulse;
    logic [CNT_W-1:0] glitch_cnt;

    modport master (
        output z_in,
        output cnt_clr,
        input  z_clean,
        input  edge_pulse,
        input  glitch_pulse,
        input  glitch_cnt
    );

    modport slave (
        input  z_in,
        input  cnt_clr,
        output z_clean,
        output edge_pulse,
        output glitch_pulse,
        output glitch_cnt
    );
endinterface

// File: rtl/hazard_glitch_filter.sv
// Synchronizes a raw hazard-prone net, accepts a new level only after it has been stable
// for STABLE_CYCLES samples, and counts rejected excursions with a saturating counter.
module hazard_glitch_filter #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hazard_glitch_filter_if.slave bus
);
    localparam int unsigned StabW = $clog2(STABLE_CYCLES) + 1;
    localparam logic [StabW-1:0] StabLast = StabW'(STABLE_CYCLES - 1);

    localparam logic [0:0] StStable = 1'b0;
    localparam logic [0:0] StCand   = 1'b1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [0:0]             state_q, state_d;
    logic [StabW-1:0]       stab_q, stab_d;
    logic                   z_clean_q, z_clean_d;
    logic                   edge_q, edge_d;
    logic                   glitch_q, glitch_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    assign s = sync_q[SYNC_STAGES-1];

    // The candidate level is always !z_clean, so only its age is tracked.
    always_comb begin
        state_d   = state_q;
        stab_d    = stab_q;
        z_clean_d = z_clean_q;
        edge_d    = 1'b0;
        glitch_d  = 1'b0;
        cnt_d     = cnt_q;
        case (state_q)
            StStable: begin
                if (s != z_clean_q) begin
                    state_d = StCand;
                    stab_d  = StabW'(1);
                end
            end
            StCand: begin
                if (s != z_clean_q) begin
                    if (stab_q == StabLast) begin
                        z_clean_d = s;
                        edge_d    = 1'b1;
                        state_d   = StStable;
                    end else begin
                        stab_d = stab_q + 1'b1;
                    end
                end else begin
                    glitch_d = 1'b1;
                    state_d  = StStable;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StStable;
        endcase
        // Clear wins over a coincident increment; the glitch strobe still fires.
        if (bus.cnt_clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            state_q   <= StStable;
            stab_q    <= '0;
            z_clean_q <= 1'b0;
            edge_q    <= 1'b0;
            glitch_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.z_in};
            state_q   <= state_d;
            stab_q    <= stab_d;
            z_clean_q <= z_clean_d;
            edge_q    <= edge_d;
            glitch_q  <= glitch_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.z_clean      = z_clean_q;
    assign bus.edge_pulse   = edge_q;
    assign bus.glitch_pulse = glitch_q;
    assign bus.glitch_cnt   = cnt_q;
endmodule

// File: tb/tb_hazard_glitch_filter.sv
// Scoreboard bench: stimulus pushes expected pulse events, a negedge monitor pops and checks.
// Instance a uses CNT_W=8 for the functional scenarios, instance b uses CNT_W=2 for saturation.
module tb_hazard_glitch_filter;
    localparam int SyncStages   = 2;
    localparam int StableCycles = 4;

    typedef struct {
        int cyc;
        bit is_edge;
        bit z;
        int cnt;
    } ev_t;

    logic clk = 1'b0;
    logic rst_a_n;
    logic rst_b_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hazard_glitch_filter_if #(.CNT_W(8)) bus_a ();
    hazard_glitch_filter_if #(.CNT_W(2)) bus_b ();

    hazard_glitch_filter #(
        .SYNC_STAGES  (SyncStages),
        .STABLE_CYCLES(StableCycles),
        .CNT_W        (8)
    ) dut_a (
        .clk  (clk),
        .rst_n(rst_a_n),
        .bus  (bus_a)
    );

    hazard_glitch_filter #(
        .SYNC_STAGES  (SyncStages),
        .STABLE_CYCLES(StableCycles),
        .CNT_W        (2)
    ) dut_b (
        .clk  (clk),
        .rst_n(rst_b_n),
        .bus  (bus_b)
    );

    ev_t q_a[$];
    ev_t q_b[$];
    int  n_checks = 0;
    int  n_errors = 0;
    bit  zc[2];
    int  cnt[2];
    int  cmax[2] = '{255, 3};

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_z(input int which, input logic v);
        if (which == 0) bus_a.z_in = v;
        else            bus_b.z_in = v;
    endtask

    task automatic set_clr(input int which, input logic v);
        if (which == 0) bus_a.cnt_clr = v;
        else            bus_b.cnt_clr = v;
    endtask

    task automatic push(input int which, input int at, input bit is_edge, input bit z, input int c);
        ev_t e;
        e.cyc = at; e.is_edge = is_edge; e.z = z; e.cnt = c;
        if (which == 0) q_a.push_back(e);
        else            q_b.push_back(e);
    endtask

    task automatic check_event(input int which, input logic ep, input logic gp, input logic z,
                               input logic [31:0] c);
        ev_t   e;
        string p = (which == 0) ? "a" : "b";
        if ((which == 0 && q_a.size() == 0) || (which == 1 && q_b.size() == 0)) begin
            check_eq({p, "_unexpected_pulse"}, 32'({ep, gp}), 32'd0);
            return;
        end
        if (which == 0) e = q_a.pop_front();
        else            e = q_b.pop_front();
        check_eq({p, "_pulse_cycle"}, cyc, e.cyc);
        check_eq({p, "_pulse_kind"}, 32'({ep, gp}), e.is_edge ? 32'd2 : 32'd1);
        if (e.is_edge) check_eq({p, "_z_after_edge"}, 32'(z), 32'(e.z));
        check_eq({p, "_cnt_at_pulse"}, c, e.cnt);
    endtask

    always @(negedge clk) begin
        if (bus_a.edge_pulse === 1'b1 || bus_a.glitch_pulse === 1'b1)
            check_event(0, bus_a.edge_pulse, bus_a.glitch_pulse, bus_a.z_clean,
                        32'(bus_a.glitch_cnt));
        if (bus_b.edge_pulse === 1'b1 || bus_b.glitch_pulse === 1'b1)
            check_event(1, bus_b.edge_pulse, bus_b.glitch_pulse, bus_b.z_clean,
                        32'(bus_b.glitch_cnt));
    end

    task automatic check_levels(input int which, input string tag);
        if (which == 0) begin
            check_eq({tag, "_z_clean"}, 32'(bus_a.z_clean), 32'(zc[0]));
            check_eq({tag, "_cnt"}, 32'(bus_a.glitch_cnt), cnt[0]);
        end else begin
            check_eq({tag, "_z_clean"}, 32'(bus_b.z_clean), 32'(zc[1]));
            check_eq({tag, "_cnt"}, 32'(bus_b.glitch_cnt), cnt[1]);
        end
    endtask

    // Drives one excursion of the given width away from the current filtered level.
    task automatic excursion(input int which, input int width, input bit clr_at_pulse,
                             input string tag);
        int n  = cyc;
        bit nz = !zc[which];
        set_z(which, nz);
        if (width >= StableCycles) begin
            push(which, n + SyncStages + StableCycles, 1'b1, nz, cnt[which]);
            zc[which] = nz;
            step(SyncStages + StableCycles + 2);
        end else begin
            if (clr_at_pulse)                  cnt[which] = 0;
            else if (cnt[which] < cmax[which]) cnt[which] = cnt[which] + 1;
            push(which, n + width + SyncStages + 1, 1'b0, zc[which], cnt[which]);
            step(width);
            set_z(which, zc[which]);
            if (clr_at_pulse) begin
                step(SyncStages);
                set_clr(which, 1'b1);
                step(1);
                set_clr(which, 1'b0);
                step(4);
            end else begin
                step(SyncStages + 5);
            end
        end
        check_levels(which, tag);
    endtask

    initial begin
        int n;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        bus_a.z_in = 1'b1;
        bus_a.cnt_clr = 1'b0;
        bus_b.z_in = 1'b0;
        bus_b.cnt_clr = 1'b0;
        zc = '{1'b0, 1'b0};
        cnt = '{0, 0};

        repeat (3) begin
            step(1);
            check_eq("rst_z_clean", 32'(bus_a.z_clean), 32'd0);
            check_eq("rst_cnt", 32'(bus_a.glitch_cnt), 32'd0);
        end

        n = cyc;
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        push(0, n + SyncStages + StableCycles, 1'b1, 1'b1, 0);
        zc[0] = 1'b1;
        step(SyncStages + StableCycles + 2);
        check_levels(0, "first_accept");

        excursion(0, 2, 1'b0, "glitch_w2");
        excursion(0, 3, 1'b0, "glitch_w3");
        excursion(0, 4, 1'b0, "accept_w4");

        // Reset two cycles into a pending candidate.
        set_z(0, 1'b1);
        step(SyncStages + 2);
        rst_a_n = 1'b0;
        set_z(0, 1'b0);
        #1;
        check_eq("midrst_outputs",
                 32'({bus_a.z_clean, bus_a.edge_pulse, bus_a.glitch_pulse, bus_a.glitch_cnt}),
                 32'd0);
        zc[0] = 1'b0;
        cnt[0] = 0;
        step(2);
        rst_a_n = 1'b1;
        step(12);
        check_levels(0, "after_midrst");

        for (int i = 0; i < 5; i++) excursion(1, 2, 1'b0, $sformatf("sat_%0d", i));
        excursion(1, 2, 1'b1, "clr_coincident");
        excursion(1, 2, 1'b0, "after_clr");

        check_eq("a_queue_drained", q_a.size(), 32'd0);
        check_eq("b_queue_drained", q_b.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
